// File: rtl/alu_sequencer.sv
// Microprogrammed sequencer for the shared counter/ALU/accumulator datapath.
// Software loads the program RAM while idle; start runs it one word per cycle.
module alu_sequencer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             prog_we,
  input  logic [AW-1:0]    prog_addr,
  input  logic [5:0]       prog_data,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             prog_err,
  output logic             div0,
  output logic [AW-1:0]    pc_out,
  output logic [2:0]       op_out,
  output logic [WIDTH-1:0] w_out,
  output logic [WIDTH-1:0] b_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic [WIDTH-1:0] w_q, w_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             perr_q, perr_d;
  logic             div0_q, div0_d;
  logic             mem_we;
  logic [5:0]       mem_q [DEPTH];

  logic [5:0]       instr;
  logic             instr_halt, instr_cnt, instr_lw;
  logic [2:0]       instr_op;
  logic [WIDTH-1:0] alu_s;

  assign instr      = mem_q[pc_q];
  assign instr_halt = instr[5];
  assign instr_cnt  = instr[4];
  assign instr_lw   = instr[3];
  assign instr_op   = instr[2:0];

  always_comb begin
    alu_s = '0;
    case (instr_op)
      3'd0: alu_s = w_q + b_q;
      3'd1: alu_s = w_q - b_q;
      3'd2: alu_s = w_q * b_q;
      3'd3: alu_s = (b_q == '0) ? '1 : w_q / b_q;
      3'd4: alu_s = w_q & b_q;
      3'd5: alu_s = w_q | b_q;
      3'd6: alu_s = w_q ^ b_q;
      default: alu_s = b_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    w_d     = w_q;
    b_d     = b_q;
    perr_d  = perr_q;
    div0_d  = div0_q;
    mem_we  = 1'b0;
    op_out  = 3'd0;
    case (state_q)
      S_IDLE: begin
        mem_we = prog_we;
        if (start) begin
          state_d = S_RUN;
          pc_d    = '0;
          w_d     = '0;
          b_d     = '0;
          div0_d  = 1'b0;
        end
      end
      S_RUN: begin
        op_out = instr_op;
        if (prog_we) perr_d = 1'b1;
        if (instr_lw) w_d = alu_s;
        if (instr_cnt) b_d = b_q + WIDTH'(1);
        if (instr_op == 3'd3 && b_q == '0) div0_d = 1'b1;
        if (instr_halt || pc_q == AW'(DEPTH - 1)) state_d = S_DONE;
        else pc_d = pc_q + AW'(1);
      end
      S_DONE: begin
        // Not busy here, so a write is accepted rather than flagged.
        mem_we  = prog_we;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      w_q     <= '0;
      b_q     <= '0;
      perr_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      w_q     <= w_d;
      b_q     <= b_d;
      perr_q  <= perr_d;
      div0_q  <= div0_d;
    end
  end

  // Program RAM survives reset so software need not reload after an abort.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem_q[prog_addr] <= prog_data;
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign prog_err = perr_q;
  assign div0     = div0_q;
  assign pc_out   = pc_q;
  assign w_out    = w_q;
  assign b_out    = b_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: cycle-level reference model plus
// directed programs with hand-computed results and randomized programs.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = 4'd0;
  logic [5:0] prog_data = 6'd0;
  logic       start = 1'b0;
  logic       busy, done, prog_err, div0;
  logic [3:0] pc_out, w_out, b_out;
  logic [2:0] op_out;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  alu_sequencer #(.WIDTH(4), .DEPTH(16), .AW(4)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .busy(busy), .done(done),
    .prog_err(prog_err), .div0(div0), .pc_out(pc_out), .op_out(op_out),
    .w_out(w_out), .b_out(b_out)
  );

  // Reference model: running/finishing flags plus plain arithmetic.
  logic [5:0] m_ram [16];
  bit         m_busy, m_done, m_perr, m_div0;
  logic [3:0] m_pc, m_w, m_b;

  function automatic logic [3:0] alu_ref(input logic [2:0] op, input logic [3:0] w, input logic [3:0] b);
    int r;
    case (op)
      3'd0: r = w + b;
      3'd1: r = w - b + 16;
      3'd2: r = w * b;
      3'd3: r = (b == 0) ? 15 : w / b;
      3'd4: r = w & b;
      3'd5: r = w | b;
      3'd6: r = w ^ b;
      default: r = b;
    endcase
    return 4'(r % 16);
  endfunction

  always @(posedge clk) begin
    logic [5:0] ins;
    logic [3:0] nw, nb;
    if (reset) begin
      m_busy = 0; m_done = 0; m_perr = 0; m_div0 = 0;
      m_pc = 0; m_w = 0; m_b = 0;
    end else if (m_busy) begin
      if (prog_we) m_perr = 1;
      ins = m_ram[m_pc];
      if (ins[2:0] == 3'd3 && m_b == 0) m_div0 = 1;
      nw = ins[3] ? alu_ref(ins[2:0], m_w, m_b) : m_w;
      nb = ins[4] ? 4'((m_b + 1) % 16) : m_b;
      if (ins[5] || m_pc == 15) begin
        m_busy = 0; m_done = 1;
      end else m_pc = m_pc + 1;
      m_w = nw; m_b = nb;
    end else begin
      if (prog_we) m_ram[prog_addr] = prog_data;
      if (m_done) m_done = 0;
      else if (start) begin
        m_busy = 1; m_pc = 0; m_w = 0; m_b = 0; m_div0 = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [2:0] exp_op;
    if (cmp_en) begin
      exp_op = m_busy ? m_ram[m_pc][2:0] : 3'd0;
      chk("cycle", {busy, done, prog_err, div0, pc_out, op_out, w_out, b_out},
                   {m_busy, m_done, m_perr, m_div0, m_pc, exp_op, m_w, m_b});
    end
  end

  function automatic logic [5:0] ins(input bit halt, input bit cnt, input bit lw, input logic [2:0] op);
    return {halt, cnt, lw, op};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load(input logic [3:0] a, input logic [5:0] d);
    prog_we = 1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 0;
  endtask

  task automatic load_test1();
    load(4'd0, ins(0, 1, 1, 3'd0));
    load(4'd1, ins(0, 1, 1, 3'd0));
    load(4'd2, ins(1, 1, 1, 3'd0));
  endtask

  // Pulses start, then waits for done; mess=1 injects random start/prog_we while running.
  task automatic run(input bit mess, output int busy_cnt, output int done_cnt);
    bit seen;
    busy_cnt = 0; done_cnt = 0; seen = 0;
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++; seen = 1;
        break;
      end
      if (mess) begin
        start = ($urandom_range(0, 3) == 0);
        prog_we = ($urandom_range(0, 5) == 0);
        prog_addr = 4'($urandom);
        prog_data = 6'($urandom);
      end
      tick();
    end
    start = 0; prog_we = 0;
    if (!seen) chk("done_timeout", 0, 1);
    tick();
    if (done) done_cnt++;
  endtask

  int bc, dc;

  initial begin
    tick(); tick();
    cmp_en = 1;
    tick();
    reset = 0;
    chk("reset_state", {busy, done, prog_err, div0, pc_out, w_out, b_out}, 0);
    for (int a = 0; a < 16; a++) load(4'(a), 6'd0);

    // Test 1
    load_test1();
    run(0, bc, dc);
    chk("t1_busy", bc, 3); chk("t1_done", dc, 1);
    chk("t1_w", w_out, 3); chk("t1_b", b_out, 3);

    // Test 2
    load(4'd0, ins(1, 0, 1, 3'd3));
    run(0, bc, dc);
    chk("t2_busy", bc, 1); chk("t2_w", w_out, 4'hF);
    chk("t2_div0", div0, 1); chk("t2_b", b_out, 0);

    // Test 3
    for (int a = 0; a < 5; a++) load(4'(a), ins(0, 1, 0, 3'd0));
    load(4'd5, ins(0, 0, 1, 3'd7));
    load(4'd6, ins(1, 0, 1, 3'd2));
    run(0, bc, dc);
    chk("t3_busy", bc, 7); chk("t3_w", w_out, 9); chk("t3_b", b_out, 5);
    chk("t3_div0_cleared", div0, 0);

    // Test 4
    for (int a = 0; a < 16; a++) load(4'(a), 6'd0);
    run(0, bc, dc);
    chk("t4_busy", bc, 16); chk("t4_done", dc, 1); chk("t4_pc", pc_out, 15);
    chk("t4_wb", {w_out, b_out}, 0);

    // Test 5
    load_test1();
    start = 1; tick(); start = 0;
    tick();
    start = 1; prog_we = 1; prog_addr = 4'd0; prog_data = ins(1, 0, 1, 3'd7);
    tick();
    start = 0; prog_we = 0;
    for (int i = 0; i < 10 && !done; i++) tick();
    tick(); tick();
    chk("t5_idle", busy, 0); chk("t5_perr", prog_err, 1);
    run(0, bc, dc);
    chk("t5_rerun_w", w_out, 3); chk("t5_rerun_b", b_out, 3); chk("t5_perr_held", prog_err, 1);

    // Test 6
    start = 1; tick(); start = 0;
    tick();
    reset = 1; tick(); reset = 0;
    chk("t6_after_reset", {busy, done, prog_err, pc_out, w_out, b_out}, 0);
    tick();
    chk("t6_no_done", done, 0);
    run(0, bc, dc);
    chk("t6_busy", bc, 3); chk("t6_w", w_out, 3); chk("t6_b", b_out, 3);

    // Same-cycle write and start: new word at 0 must execute
    prog_we = 1; prog_addr = 4'd0; prog_data = ins(1, 1, 1, 3'd5); start = 1;
    tick();
    prog_we = 0; start = 0;
    for (int i = 0; i < 10 && !done; i++) tick();
    chk("same_cycle_w", w_out, 0); chk("same_cycle_b", b_out, 1);
    tick();

    // Randomized programs
    for (int it = 0; it < 40; it++) begin
      for (int a = 0; a < 16; a++)
        load(4'(a), {($urandom_range(0, 7) == 0), 5'($urandom)});
      run(it % 3 == 0, bc, dc);
      if ($urandom_range(0, 9) == 0) begin
        reset = 1; tick(); reset = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Programmable controller for the shared 4-bit counter/ALU/accumulator datapath. It replaces a hard-wired op sequence with a small microprogram RAM that software loads through a write port. On `start` it steps through the RAM one instruction per cycle, driving op, load_w and cnt, and reports busy/done, the final accumulator value and a divide-by-zero flag.

Parameters:
- WIDTH, 4, datapath width of the accumulator w, counter b and ALU result s.
- DEPTH, 16, number of microprogram entries; must be a power of two.
- AW, 4, program address width, equal to log2(DEPTH).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- prog_we  input  1  write strobe for the program RAM.
- prog_addr  input  AW  program RAM write address.
- prog_data  input  6  instruction: [5] halt, [4] cnt, [3] load_w, [2:0] op.
- start  input  1  single-cycle pulse that begins execution at pc=0.
- busy  output  1  high while instructions are executing.
- done  output  1  one-cycle pulse after the last instruction executes.
- prog_err  output  1  sticky; set by a prog_we while busy.
- div0  output  1  sticky; set when a divide executes with b==0.
- pc_out  output  AW  current program counter.
- op_out  output  3  op currently driven to the ALU (0 when not RUN).
- w_out  output  WIDTH  accumulator value.
- b_out  output  WIDTH  counter value.

Behaviour:
- Reset values:
  - Outputs and registers: state=IDLE, busy=0, done=0, pc=0, w=0, b=0, prog_err=0, div0=0.
  - Program RAM is NOT cleared by reset.
- ALU is combinational on the current w and b. Results are truncated to WIDTH bits.
  - op 0: w+b
  - op 1: w-b (mod 2^WIDTH)
  - op 2: w*b (low WIDTH bits)
  - op 3: w/b (unsigned); if b==0, result is all ones and div0 is set
  - op 4: w&b
  - op 5: w|b
  - op 6: w^b
  - op 7: b (pass)
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - busy=0.
  - start=1 → w<=0, b<=0, pc<=0, div0<=0, next state RUN.
  - prog_we=1 → RAM[prog_addr]<=prog_data.
- RUN:
  - busy=1. Each cycle executes RAM[pc]: if load_w then w<=s; if cnt then b<=b+1, wrapping to 0 after all ones.
  - Both updates use pre-edge values of w and b.
  - halt=1 → next state DONE; pc holds.
  - Otherwise, pc==DEPTH-1 → implicit end, next state DONE.
  - Otherwise pc<=pc+1.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. w and b hold until the next start.
- Latency: a program whose first halt is at index k gives busy=1 for k+1 cycles; done follows on the next cycle.
- start while RUN or DONE is ignored; there is no restart.
- prog_we while busy: the write is dropped and prog_err is set. prog_err clears only on reset.
- Same-cycle prog_we and start in IDLE: the write is performed and execution starts. RAM is read at pc=0 on the following cycle, so the new word is visible.
- reset mid-run: abort on that edge and return to IDLE with the reset values above; no done pulse.
- op_out, load_w and cnt are 0 outside RUN.

Test Plan:
1. Load [0]=add,load_w,cnt; [1]=add,load_w,cnt; [2]=add,load_w,cnt,halt; pulse start → busy for 3 cycles, w sequence 0,1,3, b=3, done pulses once, final w_out=3.
2. Load [0]=div,load_w,halt; start → w_out=4'hF, div0=1, b_out=0, busy for 1 cycle.
3. Load [0..4]=cnt only; [5]=pass,load_w; [6]=mul,load_w,halt; start → b=5, w=5, then w=25 mod 16=9; done after 7 busy cycles.
4. All-zero program (no halt) → busy for exactly 16 cycles, pc_out reaches 15, done pulses, w=0, b=0.
5. Pulse start and prog_we during RUN → start ignored, RAM unchanged (verified on rerun), prog_err=1 held until reset.
6. Assert reset at cycle 2 of test 1 → next cycle busy=0, w=0, b=0, pc=0, no done. Re-start without reprogramming → same result as test 1 (RAM retained).
